// File: rtl/adder_seq.sv
// adder_seq: multi-precision add/subtract sequencer.
// One SLICE_W-bit add slice (A + B + CI, B optionally inverted) is reused
// NSLICES times per operation, LSB chunk first, with the carry chained
// through a register. Optional status flags (out_zero, out_ovf) are
// compiled in when the macro ADDER_SEQ_FLAGS_EN is defined.
module adder_seq #(
    parameter int SLICE_W = 8,
    parameter int NSLICES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*NSLICES-1:0]  in_a,
    input  logic [SLICE_W*NSLICES-1:0]  in_b,
    input  logic                        in_sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*NSLICES-1:0]  out_sum,
    output logic                        out_co,
`ifdef ADDER_SEQ_FLAGS_EN
    output logic                        out_zero,
    output logic                        out_ovf,
`endif
    output logic                        busy
);

    localparam int W     = SLICE_W * NSLICES;
    localparam int IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q,     a_d;
    logic [W-1:0]       b_q,     b_d;
    logic               sub_q,   sub_d;
    logic [W-1:0]       sum_q,   sum_d;
    logic               co_q,    co_d;
`ifdef ADDER_SEQ_FLAGS_EN
    logic               zero_q,  zero_d;
    logic               ovf_q,   ovf_d;
`endif

    logic [SLICE_W-1:0] a_chunk;
    logic [SLICE_W-1:0] b_chunk;
    logic [SLICE_W:0]   slice_res;
    logic               slice_co;
    logic               slice_cin_msb;

    // Shared add slice: selected chunk of A plus (optionally inverted) B plus carry.
    always_comb begin
        a_chunk       = a_q[idx_q*SLICE_W +: SLICE_W];
        b_chunk       = sub_q ? ~b_q[idx_q*SLICE_W +: SLICE_W]
                              :  b_q[idx_q*SLICE_W +: SLICE_W];
        slice_res     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{SLICE_W{1'b0}}, carry_q};
        slice_co      = slice_res[SLICE_W];
        // Carry into the slice MSB, recovered from the MSB sum bit.
        slice_cin_msb = a_chunk[SLICE_W-1] ^ b_chunk[SLICE_W-1] ^ slice_res[SLICE_W-1];
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        co_d    = co_q;
`ifdef ADDER_SEQ_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = in_sub;
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
                carry_d = slice_co;
                if (idx_q == IDX_LAST) begin
                    co_d    = slice_co;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef ADDER_SEQ_FLAGS_EN
                    zero_d  = (sum_d == '0);
                    ovf_d   = slice_cin_msb ^ slice_co;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
`ifdef ADDER_SEQ_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
`ifdef ADDER_SEQ_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_sum   = sum_q;
    assign out_co    = co_q;
`ifdef ADDER_SEQ_FLAGS_EN
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq with a result scoreboard queue.
// Flag checks are compiled in when ADDER_SEQ_FLAGS_EN is defined.
module tb_adder_seq;

    localparam int SLICE_W = 8;
    localparam int NSLICES = 4;
    localparam int W       = SLICE_W * NSLICES;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         busy;
`ifdef ADDER_SEQ_FLAGS_EN
    logic         out_zero;
    logic         out_ovf;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    adder_seq #(.SLICE_W(SLICE_W), .NSLICES(NSLICES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
`ifdef ADDER_SEQ_FLAGS_EN
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result: whole-word arithmetic, independent of slicing.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic [W-1:0] low;
        bx     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
        low    = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, sub};
        e.sum  = full[W-1:0];
        e.co   = full[W];
        e.zero = (full[W-1:0] == '0);
        e.ovf  = low[W-1] ^ full[W];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and hold in_valid until accepted; optionally score it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit push);
        int n;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(n), 64'd0);
        tick();
        in_valid = 1'b0;
        if (push) sb.push_back(model(a, b, sub));
    endtask

    // Wait for a result, optionally stall the sink, then compare against the scoreboard.
    task automatic recv(input string tag, input bit chk_lat, input int hold);
        int           n;
        exp_t         e;
        logic [W-1:0] s0;
        logic         c0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 64'(n), 64'd0);
            return;
        end
        if (chk_lat) chk({tag, "_latency"}, 64'(n), 64'(NSLICES));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sum"}, 64'(out_sum), 64'(e.sum));
        chk({tag, "_co"},  64'(out_co),  64'(e.co));
`ifdef ADDER_SEQ_FLAGS_EN
        chk({tag, "_zero"}, 64'(out_zero), 64'(e.zero));
        chk({tag, "_ovf"},  64'(out_ovf),  64'(e.ovf));
`endif
        s0 = out_sum;
        c0 = out_co;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready),  64'd0);
            chk({tag, "_hold_busy"},  64'(busy),      64'd0);
            chk({tag, "_hold_sum"},   64'(out_sum),   64'(s0));
            chk({tag, "_hold_co"},    64'(out_co),    64'(c0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_release_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        exp_t e;
        int   acc_cnt;
        int   rcv_cnt;
        int   op_i;
        logic [W-1:0] bb_a [3];
        logic [W-1:0] bb_b [3];
        logic         bb_s [3];
        logic         acc, fire;
        logic [W-1:0] obs_sum;
        logic         obs_co;

        // Reset state
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'd0);
        chk("rst_out_co",    64'(out_co),    64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Carry across a slice boundary, with latency check
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        recv("carry_chain", 1'b1, 0);

        // Full wrap
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        recv("wrap", 1'b1, 0);

        // Subtract with borrow, then without
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        recv("sub_borrow", 1'b1, 0);
        send(32'd5, 32'd3, 1'b1, 1'b1);
        recv("sub_small", 1'b1, 0);

        // Signed overflow
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        recv("ovf", 1'b1, 0);

        // Mixed patterns
        send(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
        recv("mix_add", 1'b0, 0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        recv("mix_sub_ovf", 1'b0, 0);

        // Busy during RUN, then reset in the second RUN cycle
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
        chk("run_busy",     64'(busy),     64'd1);
        chk("run_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sum",   64'(out_sum),   64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        tick();
        rst = 1'b0;
        tick();
        send(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b1);
        recv("after_rst", 1'b1, 0);

        // Backpressure: sink stalls 10 cycles while a new op waits at the input
        send(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b1);
        in_a     = 32'h0000_0010;
        in_b     = 32'h0000_0020;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        recv("bp", 1'b0, 10);
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
        recv("bp_next", 1'b1, 0);

        // Back-to-back with in_valid and out_ready held high
        bb_a[0] = 32'h0000_0001; bb_b[0] = 32'h0000_0002; bb_s[0] = 1'b0;
        bb_a[1] = 32'h0000_0100; bb_b[1] = 32'h0000_0200; bb_s[1] = 1'b1;
        bb_a[2] = 32'hFFFF_0000; bb_b[2] = 32'h0001_0000; bb_s[2] = 1'b0;
        op_i     = 0;
        acc_cnt  = 0;
        rcv_cnt  = 0;
        in_a     = bb_a[0];
        in_b     = bb_b[0];
        in_sub   = bb_s[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && rcv_cnt < 3; cyc++) begin
            acc     = in_valid && in_ready;
            fire    = out_valid && out_ready;
            obs_sum = out_sum;
            obs_co  = out_co;
            tick();
            if (acc) begin
                sb.push_back(model(bb_a[op_i], bb_b[op_i], bb_s[op_i]));
                acc_cnt++;
                op_i++;
                if (op_i < 3) begin
                    in_a   = bb_a[op_i];
                    in_b   = bb_b[op_i];
                    in_sub = bb_s[op_i];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (fire) begin
                rcv_cnt++;
                if (sb.size() == 0) begin
                    chk("b2b_sb_empty", 64'd0, 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("b2b_sum", 64'(obs_sum), 64'(e.sum));
                    chk("b2b_co",  64'(obs_co),  64'(e.co));
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepted", 64'(acc_cnt), 64'd3);
        chk("b2b_received", 64'(rcv_cnt), 64'd3);
        tick();
        tick();
        chk("b2b_no_extra", 64'(out_valid), 64'd0);
        chk("sb_drained",   64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Multi-precision add/subtract sequencer built around one SLICE_W-bit ripple-carry add slice (A + B + CI with optional B inversion, the form the techmap builds from FAX1 cells).
- Accepts wide operands over a valid/ready handshake and feeds them through the slice one SLICE_W-bit chunk per cycle, LSB first, chaining the carry in a register.
- Sits between the example's operand source and result sink; lets a small adder serve wide arithmetic in the tsmc018 flow.

Parameters:
- SLICE_W, 8, width of the shared add slice in bits
- NSLICES, 4, chunks per operation; operand width W = SLICE_W*NSLICES

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  sequencer can accept
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result held
- out_ready  input  1  sink accepts result
- out_sum  output  W  result
- out_co  output  1  carry-out of MSB slice (for sub: 1 = no borrow)
- busy  output  1  high in RUN

Behaviour:
- Reset (async assert, any state, including mid-operation): state=IDLE; in_ready=1, out_valid=0, out_sum=0, out_co=0, busy=0; slice index, carry and operand registers cleared. A partial operation is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a, in_b, in_sub; set carry=in_sub, idx=0; go to RUN.
  - RUN: busy=1, in_ready=0. Each cycle the slice computes a_chunk + (sub ? ~b_chunk : b_chunk) + carry on chunk idx. The sum chunk is written to out_sum[idx*SLICE_W +: SLICE_W] and carry is updated from the slice carry-out. idx increments. After the cycle with idx=NSLICES-1: out_co=slice carry, go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready: out_valid=0 and go to IDLE.
- Latency: accept edge, then NSLICES RUN cycles; out_valid rises on the edge ending the last RUN cycle, i.e. NSLICES cycles after accept. Throughput is one operation per NSLICES+2 cycles minimum.
- out_sum and out_co are stable while out_valid=1. out_sum is undefined-but-deterministic (partial) during RUN; the sink must ignore it.
- Inputs are sampled only at accept; later changes to in_a/in_b/in_sub have no effect.
- Arithmetic is modulo 2^W, unsigned. Sub is two's complement via inverted B with CI=1, so A-B = A + ~B + 1.
- in_valid while not in IDLE is held off (in_ready=0), never dropped. The source must hold it.
- NSLICES=1 is legal: a single RUN cycle.
- idx counter width is clog2(NSLICES), minimum 1. idx never exceeds NSLICES-1.

Optional Feature:
- Macro ADDER_SEQ_FLAGS_EN.
- When defined: extra outputs out_zero (1) and out_ovf (1), valid with out_valid and reset to 0.
  - out_zero=1 iff out_sum==0.
  - out_ovf = signed overflow: carry into MSB bit XOR carry out of MSB bit, computed in the last RUN cycle.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN: assert rst in 2nd RUN cycle -> immediately state IDLE, in_ready=1, out_valid=0, out_sum=0; next op gives a correct result.
- Add with carry chain: A=0x000000FF, B=0x00000001, sub=0 -> after 4 cycles out_sum=0x00000100, out_co=0 (carry propagates across slice boundary).
- Full wrap: A=0xFFFFFFFF, B=0x00000001, add -> out_sum=0x00000000, out_co=1; with FLAGS_EN, out_zero=1, out_ovf=0.
- Subtract with borrow: A=0x00000000, B=0x00000001, sub=1 -> out_sum=0xFFFFFFFF, out_co=0. With A=5, B=3 -> out_sum=2, out_co=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_sum/out_co stable, in_ready=0 throughout, new in_valid not accepted; release -> IDLE next cycle.
- Signed overflow (FLAGS_EN): A=0x7FFFFFFF, B=1, add -> out_sum=0x80000000, out_ovf=1, out_co=0. Back-to-back ops with in_valid held high -> each accepted exactly once, results in order.
